axis_rr_arbiter: RTL and testbench

Round-robin, packet-locked arbiter that shares one AXI-Stream output, typically the input of `skid_buffer`, between `N_SRC` AXI-Stream requesters. A packet is exactly `N_BEATS` beats. Once a source is granted, it owns the output until its last beat completes. The datapath is a zero-latency mux. Grant state, beat counting and fairness are registered.

---
 rtl/axis_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/axis_rr_arbiter.sv | 108 ++++++++++
 tb/tb_axis_rr_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and width helpers for the round-robin AXI-Stream arbiter.
// Pure declarations: no logic, no latency, no flow control of its own.
package axis_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} arb_state_t;

  localparam int DEF_N_SRC   = 4;
  localparam int DEF_WORD_W  = 8;
  localparam int DEF_BUS_W   = 32;
  localparam int DEF_N_BEATS = 10;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int words_per_beat(input int bus_w, input int word_w);
    return bus_w / word_w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester strictly after 'last', wrapping; purely combinational.
// Zero latency; no flow control, the caller decides when the pick is consumed.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int IDX_W = clog2_min1(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N_SRC-1:0] req_dbl;
  logic [2*N_SRC-1:0] window;
  logic [2*N_SRC-1:0] masked;
  logic               found;

  always_comb begin
    req_dbl = {req, req};
    window  = '0;
    // The N_SRC positions just above 'last' in the doubled vector cover every
    // source exactly once in round-robin order, so a plain lowest-bit search
    // handles the wrap without any modulo arithmetic.
    for (int i = 0; i < 2*N_SRC; i++) begin
      window[i] = (i > int'(last)) && (i <= int'(last) + N_SRC);
    end
    masked = req_dbl & window;

    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 2*N_SRC; i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        idx   = (i >= N_SRC) ? IDX_W'(i - N_SRC) : IDX_W'(i);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter muxing N_SRC AXI-Stream sources onto one output.
// Zero-latency datapath, one idle bubble per packet; m_ready passes straight to the owner only.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N_SRC   = DEF_N_SRC,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int BUS_W   = DEF_BUS_W,
  parameter int N_BEATS = DEF_N_BEATS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC-1:0]              s_valid,
  output logic [N_SRC-1:0]              s_ready,
  input  logic [N_SRC-1:0][BUS_W-1:0]   s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [BUS_W-1:0]              m_data,
  output logic [$clog2(N_SRC)-1:0]      m_grant,
  output logic                          busy
);

  localparam int IDX_W          = clog2_min1(N_SRC);
  localparam int CNT_W          = clog2_min1(N_BEATS);
  localparam int WORDS_PER_BEAT = words_per_beat(BUS_W, WORD_W);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [IDX_W-1:0] last_grant, last_grant_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] mux_words;

  rr_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (s_valid),
    .last (last_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(N_SRC - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    m_valid        = 1'b0;
    s_ready        = '0;

    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_nxt    = pick_idx;
          beat_cnt_nxt = '0;
          state_nxt    = LOCK;
        end
      end

      LOCK: begin
        m_valid        = s_valid[grant];
        s_ready[grant] = m_ready;
        // The lock survives an owner valid drop; only the final beat releases it.
        if (s_valid[grant] && m_ready) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt   = '0;
            last_grant_nxt = grant;
            state_nxt      = IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign mux_words = s_data[grant];
  assign m_data    = mux_words;
  assign m_grant   = grant;
  assign busy      = (state == LOCK);

  a_grant_range: assert property (@(posedge clk) disable iff (rst) int'(grant) < N_SRC);
  a_cnt_range:   assert property (@(posedge clk) disable iff (rst) int'(beat_cnt) < N_BEATS);
  a_idle_quiet:  assert property (@(posedge clk) disable iff (rst)
                                  (state == IDLE) |-> (!m_valid && s_ready == '0));

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: randomized sources and sink against a rule-level model.
`timescale 1ns/1ps
module tb_axis_rr_arbiter;

  localparam int N_SRC   = 4;
  localparam int WORD_W  = 8;
  localparam int BUS_W   = 32;
  localparam int N_BEATS = 10;

  logic                        clk     = 1'b0;
  logic                        rst     = 1'b1;
  logic [N_SRC-1:0]            s_valid = '0;
  logic [N_SRC-1:0]            s_ready;
  logic [N_SRC-1:0][BUS_W-1:0] s_data  = '0;
  logic                        m_valid;
  logic                        m_ready = 1'b0;
  logic [BUS_W-1:0]            m_data;
  logic [$clog2(N_SRC)-1:0]    m_grant;
  logic                        busy;

  always #5 clk = ~clk;

  axis_rr_arbiter #(
    .N_SRC   (N_SRC),
    .WORD_W  (WORD_W),
    .BUS_W   (BUS_W),
    .N_BEATS (N_BEATS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_grant (m_grant),
    .busy    (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // stimulus configuration, changed by the sequencer
  logic [N_SRC-1:0] src_mask = '0;
  int vpct     = 100;
  int rpct     = 100;
  bit drop_en  = 1'b0;
  int drop_src = 2;

  // source-side state
  bit               presenting [N_SRC];
  bit               acc        [N_SRC];
  int               sent       [N_SRC];
  int               hold       [N_SRC];
  logic [BUS_W-1:0] cur        [N_SRC];
  logic [BUS_W-1:0] exp_q      [N_SRC][$];
  int src_beats = 0;
  int dut_beats = 0;

  // reference model of the arbitration rules
  bit mdl_lock  = 1'b0;
  int mdl_owner = 0;
  int mdl_cnt   = 0;
  int mdl_last  = N_SRC - 1;
  int pkt_total = 0;
  int pkt_done  [N_SRC];
  int wait_cnt  [N_SRC];
  int grant_log [$];
  int first_cyc [$];
  bit mon_en    = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s at cycle %0d", name, what, cyc);
  endfunction

  function automatic void model_reset();
    mdl_lock  = 1'b0;
    mdl_owner = 0;
    mdl_cnt   = 0;
    mdl_last  = N_SRC - 1;
    for (int i = 0; i < N_SRC; i++) wait_cnt[i] = 0;
  endfunction

  function automatic bit all_idle();
    bit r = !mdl_lock;
    for (int i = 0; i < N_SRC; i++)
      if (presenting[i] || sent[i] != 0 || hold[i] != 0) r = 1'b0;
    return r;
  endfunction

  // Sources: a beat, once offered, is held until accepted; new packets start only if enabled.
  initial begin : driver
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        for (int i = 0; i < N_SRC; i++) begin
          presenting[i] = 1'b0;
          sent[i]       = 0;
          hold[i]       = 0;
          exp_q[i].delete();
        end
      end else begin
        for (int i = 0; i < N_SRC; i++) begin
          if (acc[i]) begin
            presenting[i] = 1'b0;
            sent[i]       = (sent[i] + 1) % N_BEATS;
            if (drop_en && i == drop_src && sent[i] == 5) begin
              hold[i] = 5;
              drop_en = 1'b0;
            end
          end
          if (hold[i] != 0) begin
            hold[i]--;
          end else if (!presenting[i] && (sent[i] != 0 || src_mask[i]) &&
                       $urandom_range(99) < 32'(vpct)) begin
            presenting[i] = 1'b1;
            cur[i]        = $urandom;
            exp_q[i].push_back(cur[i]);
          end
        end
      end
      for (int i = 0; i < N_SRC; i++) begin
        s_valid[i] = presenting[i];
        s_data[i]  = presenting[i] ? cur[i] : BUS_W'($urandom);
      end
      m_ready = ($urandom_range(99) < 32'(rpct));
      #1;
      for (int i = 0; i < N_SRC; i++) begin
        acc[i] = s_valid[i] && (s_ready[i] === 1'b1) && !rst;
        if (acc[i]) src_beats++;
      end
    end
  end

  // Monitor: compare DUT outputs with the model, then advance the model across the edge.
  initial begin : monitor
    forever begin
      bit               exp_v;
      logic [N_SRC-1:0] exp_r;
      int               win;
      @(negedge clk);
      #3;
      cyc++;
      if (mon_en) begin
        exp_v = mdl_lock && s_valid[mdl_owner];
        exp_r = '0;
        if (mdl_lock && m_ready) exp_r[mdl_owner] = 1'b1;
        chk("busy",    64'(busy),    64'(mdl_lock));
        chk("m_grant", 64'(m_grant), 64'(mdl_owner));
        chk("m_valid", 64'(m_valid), 64'(exp_v));
        chk("s_ready", 64'(s_ready), 64'(exp_r));
        if (!rst && m_valid === 1'b1 && m_ready) dut_beats++;

        if (rst) begin
          model_reset();
        end else if (!mdl_lock) begin
          win = -1;
          for (int k = 1; k <= N_SRC; k++) begin
            int j;
            j = (mdl_last + k) % N_SRC;
            if (win < 0 && s_valid[j]) win = j;
          end
          if (win >= 0) begin
            for (int i = 0; i < N_SRC; i++) begin
              if (s_valid[i] && i != win) begin
                wait_cnt[i]++;
                checks++;
                if (wait_cnt[i] > N_SRC - 1) begin
                  failures++;
                  $display("FAIL starvation: source %0d waited %0d packets, limit %0d", i, wait_cnt[i], N_SRC - 1);
                end
              end else begin
                wait_cnt[i] = 0;
              end
            end
            mdl_lock  = 1'b1;
            mdl_owner = win;
            mdl_cnt   = 0;
          end
        end else if (exp_v && m_ready) begin
          if (mdl_cnt == 0) begin
            grant_log.push_back(int'(m_grant));
            first_cyc.push_back(cyc);
          end
          if (exp_q[mdl_owner].size() == 0)
            fail_now("m_data", "no beat outstanding for owner");
          else
            chk("m_data", 64'(m_data), 64'(exp_q[mdl_owner].pop_front()));
          mdl_cnt++;
          if (mdl_cnt == N_BEATS) begin
            mdl_lock = 1'b0;
            mdl_last = mdl_owner;
            mdl_cnt  = 0;
            pkt_total++;
            pkt_done[mdl_owner]++;
          end
        end
      end
    end
  end

  task automatic wait_pkts(input int target, input int budget, input string name);
    int n = 0;
    while (pkt_total < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pkt_total < target) fail_now(name, "timed out waiting for packets");
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!all_idle() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!all_idle()) fail_now(name, "timed out waiting for idle");
  endtask

  initial begin : sequencer
    int base;
    int ls;
    int n;
    int prev1;

    // reset state
    src_mask = 4'b0001;
    vpct = 100;
    rpct = 100;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    #4;
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_s_ready", 64'(s_ready), 64'd0);
    chk("reset_m_grant", 64'(m_grant), 64'd0);
    chk("reset_busy",    64'(busy),    64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single source, full rate: back-to-back packets separated by one bubble
    wait_pkts(3, 200, "single_src");
    if (grant_log.size() >= 3) begin
      for (int j = 0; j < 3; j++) chk("single_grant", 64'(grant_log[j]), 64'd0);
      chk("single_spacing", 64'(first_cyc[1] - first_cyc[0]), 64'(N_BEATS + 1));
      chk("single_spacing", 64'(first_cyc[2] - first_cyc[1]), 64'(N_BEATS + 1));
    end else begin
      fail_now("single_grant", "too few packets logged");
    end

    // all sources continuously valid: strict rotation
    src_mask = '1;
    base = pkt_total;
    ls   = grant_log.size();
    wait_pkts(base + 40, 1000, "all_src");
    if (grant_log.size() >= ls + 40) begin
      for (int j = 1; j < 40; j++) begin
        chk("rr_order",   64'(grant_log[ls + j]), 64'((grant_log[ls + j - 1] + 1) % N_SRC));
        chk("rr_spacing", 64'(first_cyc[ls + j] - first_cyc[ls + j - 1]), 64'(N_BEATS + 1));
      end
    end else begin
      fail_now("rr_order", "too few packets logged");
    end

    // owner drops valid mid-packet while another source waits
    src_mask = 4'b1100;
    drop_src = 2;
    drop_en  = 1'b1;
    base     = pkt_total;
    n = 0;
    while ((drop_en || pkt_total < base + 6) && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (drop_en || pkt_total < base + 6) fail_now("valid_drop", "timed out");

    // skip non-requesters: last grant 1, requests on 3 and 0
    src_mask = '0;
    wait_idle("skip_drain");
    prev1 = pkt_done[1];
    src_mask = 4'b0010;
    n = 0;
    while (pkt_done[1] == prev1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    src_mask = '0;
    wait_idle("skip_prep");
    grant_log.delete();
    first_cyc.delete();
    src_mask = 4'b1001;
    n = 0;
    while (grant_log.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (grant_log.size() >= 2) begin
      chk("skip_grant_first",  64'(grant_log[0]), 64'd3);
      chk("skip_grant_second", 64'(grant_log[1]), 64'd0);
    end else begin
      fail_now("skip_grant", "grants not observed");
    end

    // reset in the middle of a packet
    src_mask = '1;
    n = 0;
    while (!(mdl_lock && mdl_cnt == 6) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!(mdl_lock && mdl_cnt == 6)) fail_now("mid_reset", "beat 6 never reached");
    rst = 1'b1;
    grant_log.delete();
    first_cyc.delete();
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("mid_reset_m_valid", 64'(m_valid), 64'd0);
    chk("mid_reset_busy",    64'(busy),    64'd0);
    chk("mid_reset_s_ready", 64'(s_ready), 64'd0);
    n = 0;
    while (grant_log.size() < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (grant_log.size() >= 1) chk("post_reset_grant", 64'(grant_log[0]), 64'd0);
    else fail_now("post_reset_grant", "no grant after reset");

    // random valid and 50% backpressure over many packets
    vpct = 60;
    rpct = 50;
    base = pkt_total;
    wait_pkts(base + 500, 40000, "random");

    src_mask = '0;
    rpct = 100;
    wait_idle("final_drain");
    chk("beat_count", 64'(dut_beats), 64'(src_beats));
    for (int i = 0; i < N_SRC; i++) chk("leftover_beats", 64'(exp_q[i].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
